// File: rtl/if_id_queue_pkg.sv
// Shared types and helpers for the Fetch->Decode instruction queue.
package if_id_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic                prediction;
  } fetch_pkt_t;

  // Only the two length bits matter; callers pass instr[1:0].
  function automatic logic is_rv32_len(input logic [1:0] instr);
    return instr == 2'b11;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/Decode handshake bundle around the instruction queue.
interface if_id_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_instr;
  logic            i_prediction;
  logic            i_vld;
  logic            o_rdy;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_instr;
  logic            o_prediction;
  logic            o_illegal;
  logic            o_vld;
  logic            i_dec_rdy;
  logic            i_flush;
  logic [CW-1:0]   o_count;

  modport slave (
    input  i_pc, i_instr, i_prediction, i_vld, i_dec_rdy, i_flush,
    output o_rdy, o_pc, o_instr, o_prediction, o_illegal, o_vld, o_count
  );

  modport master (
    output i_pc, i_instr, i_prediction, i_vld, i_dec_rdy, i_flush,
    input  o_rdy, o_pc, o_instr, o_prediction, o_illegal, o_vld, o_count
  );

endinterface

// File: rtl/if_id_queue_fifo_ptr_ctrl.sv
// Generic circular-buffer pointer/occupancy controller; flush overrides push/pop.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fifo_ptr_ctrl: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

endmodule

// File: rtl/if_id_queue.sv
// Fetch->Decode instruction queue with flush and illegal-length tagging.
// Optional input fall-through when empty: define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave q
);

  if (XLEN != XLEN_DEF) begin : g_xlen_chk
    $error("if_id_queue: storage packet is fixed at XLEN_DEF bits");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, byp;

  fetch_pkt_t in_pkt, head_pkt;
  fetch_pkt_t mem_q [DEPTH];
  fetch_pkt_t mem_d [DEPTH];

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp = empty & q.i_vld & ~q.i_flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed instruction taken by Decode in the same cycle is never stored.
  assign push = q.i_vld & ~full & ~(byp & q.i_dec_rdy);
  assign pop  = ~empty & q.i_dec_rdy;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (q.i_flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    in_pkt.pc         = q.i_pc;
    in_pkt.instr      = q.i_instr;
    in_pkt.prediction = q.i_prediction;
  end

  always_comb begin
    mem_d = mem_q;
    if (push && !q.i_flush) mem_d[wr_ptr] = in_pkt;
  end

  // Entry contents are don't-care after reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head_pkt = '0;
    if (byp)         head_pkt = in_pkt;
    else if (!empty) head_pkt = mem_q[rd_ptr];
  end

  assign q.o_vld        = ~empty | byp;
  assign q.o_rdy        = ~full;
  assign q.o_count      = count;
  assign q.o_pc         = head_pkt.pc;
  assign q.o_instr      = head_pkt.instr;
  assign q.o_prediction = head_pkt.prediction;
  assign q.o_illegal    = q.o_vld & ~is_rv32_len(head_pkt.instr[1:0]);

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4, XLEN=32).
module tb_if_id_queue;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  if_id_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

  if_id_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] instr);
    bus.i_vld        = vld;
    bus.i_pc         = pc;
    bus.i_instr      = instr;
    bus.i_prediction = pc[2];
  endtask

  // Fetch must hold its payload while stalled by a full queue.
  logic        hold_q = 1'b0;
  logic [31:0] pc_q, instr_q;
  logic        pred_q;
  always @(posedge clk) begin
    if (!rst && hold_q) begin
      checks++;
      assert (bus.i_pc === pc_q && bus.i_instr === instr_q && bus.i_prediction === pred_q) else begin
        errors++;
        $error("FAIL fetch_hold: observed pc %0h expected %0h", bus.i_pc, pc_q);
      end
    end
    hold_q  <= !rst && bus.i_vld && !bus.o_rdy;
    pc_q    <= bus.i_pc;
    instr_q <= bus.i_instr;
    pred_q  <= bus.i_prediction;
  end

  initial begin
    rst           = 1'b1;
    bus.i_dec_rdy = 1'b0;
    bus.i_flush   = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_vld",   bus.o_vld, 0);
    chk("rst_rdy",   bus.o_rdy, 1);
    chk("rst_count", bus.o_count, 0);
    chk("rst_pc",    bus.o_pc, 0);
    chk("rst_instr", bus.o_instr, 0);
    chk("rst_ill",   bus.o_illegal, 0);
    tick();
    rst = 1'b0;

    // single instruction through an empty queue
    drive(1'b1, 32'h0, 32'h0000_0013);
    bus.i_dec_rdy = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("t1_vld",   bus.o_vld, 1);
    chk("t1_pc",    bus.o_pc, 0);
    chk("t1_instr", bus.o_instr, 32'h13);
    chk("t1_count", bus.o_count, 1);
    tick();
    chk("t1_vld_after",   bus.o_vld, 0);
    chk("t1_count_after", bus.o_count, 0);

    // fill to full, hold off a fifth, then drain in order
    bus.i_dec_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k), 32'h0000_0013);
      tick();
    end
    chk("full_count", bus.o_count, 4);
    chk("full_rdy",   bus.o_rdy, 0);
    drive(1'b1, 32'h10, 32'h0000_0013);
    tick();
    chk("full_count_held", bus.o_count, 4);
    chk("full_head_held",  bus.o_pc, 0);
    bus.i_dec_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", bus.o_pc, 64'(4 * k));
      tick();
      if (k == 1) drive(1'b0, 32'h0, 32'h0);
    end
    chk("fifth_pc",    bus.o_pc, 32'h10);
    chk("fifth_count", bus.o_count, 1);
    tick();
    chk("drain_empty", bus.o_count, 0);

    // steady push+pop at count=2, across several pointer wraps
    bus.i_dec_rdy = 1'b0;
    drive(1'b1, 32'h100, 32'h0000_0013);
    tick();
    drive(1'b1, 32'h104, 32'h0000_0013);
    tick();
    bus.i_dec_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h108 + 32'(4 * i), 32'h0000_0013);
      chk("stream_pc",    bus.o_pc, 64'(32'h100 + 32'(4 * i)));
      chk("stream_count", bus.o_count, 2);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    chk("stream_tail_pc", bus.o_pc, 32'h150);
    tick();
    tick();
    chk("stream_empty", bus.o_count, 0);

    // flush at count=3 with a simultaneous push
    bus.i_dec_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 32'h0000_0013);
      tick();
    end
    chk("pre_flush_count", bus.o_count, 3);
    drive(1'b1, 32'h20C, 32'h0000_0013);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_vld",   bus.o_vld, 0);
    chk("flush_count", bus.o_count, 0);
    chk("flush_pc",    bus.o_pc, 0);
    drive(1'b1, 32'h300, 32'h0000_0013);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("post_flush_pc",    bus.o_pc, 32'h300);
    chk("post_flush_count", bus.o_count, 1);
    bus.i_dec_rdy = 1'b1;
    tick();
    chk("post_flush_empty", bus.o_count, 0);

    // illegal-length tagging
    bus.i_dec_rdy = 1'b0;
    drive(1'b1, 32'h400, 32'h0000_4501);
    tick();
    chk("ill_vld", bus.o_vld, 1);
    chk("ill_set", bus.o_illegal, 1);
    drive(1'b1, 32'h404, 32'h0000_0013);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ill_hold", bus.o_illegal, 1);
    chk("ill_hold_instr", bus.o_instr, 32'h4501);
    bus.i_dec_rdy = 1'b1;
    tick();
    chk("legal_instr", bus.o_instr, 32'h13);
    chk("legal_clr",   bus.o_illegal, 0);
    tick();
    chk("ill_empty", bus.o_illegal, 0);

    // async reset mid-stream at count=2
    bus.i_dec_rdy = 1'b0;
    drive(1'b1, 32'h500, 32'h0000_0013);
    tick();
    drive(1'b1, 32'h504, 32'h0000_0013);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("pre_rst_count", bus.o_count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld",   bus.o_vld, 0);
    chk("arst_count", bus.o_count, 0);
    chk("arst_rdy",   bus.o_rdy, 1);
    tick();
    rst = 1'b0;

`ifdef IF_ID_QUEUE_BYPASS_EN
    drive(1'b1, 32'h600, 32'h0000_0013);
    bus.i_dec_rdy = 1'b1;
    #1;
    chk("byp_vld", bus.o_vld, 1);
    chk("byp_pc",  bus.o_pc, 32'h600);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("byp_count", bus.o_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
